// File: rtl/ysyx_22050019_pkg.sv
// Shared types and constants for the write-back arbitration slice.
package ysyx_22050019_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned CSR_DIFF_N = 4;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_EXU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

    // One write-back request as seen at the arbiter input.
    typedef struct packed {
        logic                         we;
        logic [4:0]                   waddr;
        logic [XLEN-1:0]              wdata;
        logic [XLEN-1:0]              pc;
        logic [CSR_DIFF_N*XLEN-1:0]   csr_diff;
    } wb_req_t;

endpackage

// File: rtl/ysyx_22050019_wb_age_prio.sv
// Two-way grant between EXU and LSU: LSU wins collisions until the EXU
// request has lost AGE_MAX consecutive cycles, then EXU wins once.
// age_q is the only state; age_q == AGE_MAX is the "EXU priority" condition.
module ysyx_22050019_wb_age_prio
    import ysyx_22050019_pkg::*;
#(
    parameter int unsigned AGE_MAX = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    exu_valid,
    input  logic    lsu_valid,
    output logic    exu_grant,
    output logic    lsu_grant,
    output wb_src_e src
);

    localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

    logic [3:0] age_q;
    logic       exu_pri;

    assign exu_pri = (age_q == AGE_LIM);

    // Grant: LSU first on collision unless the EXU request has aged out.
    always_comb begin
        lsu_grant = lsu_valid & ~(exu_valid & exu_pri);
        exu_grant = exu_valid & ~lsu_grant;
        src       = WB_NONE;
        if (exu_grant) begin
            src = WB_EXU;
        end else if (lsu_grant) begin
            src = WB_LSU;
        end
    end

    // Aging: count consecutive lost cycles of a pending EXU request, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 4'd0;
        end else if (exu_valid && !exu_grant) begin
            if (age_q != AGE_LIM) begin
                age_q <= age_q + 4'd1;
            end
        end else begin
            age_q <= 4'd0;
        end
    end

endmodule

// File: rtl/ysyx_22050019_wb_arbiter.sv
// Register-file write-back arbiter: picks EXU or LSU result each cycle and
// registers the write port, the commit/difftest record and instret.
// Handshake: a source offers with valid; the result is taken in the cycle
// where ready is high (ready is combinational, at most one high per cycle).
// Datapath width comes from ysyx_22050019_pkg::XLEN.
module ysyx_22050019_wb_arbiter
    import ysyx_22050019_pkg::*;
#(
    parameter int unsigned AGE_MAX = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         exu_valid_i,
    output logic                         exu_ready_o,
    input  logic                         exu_we_i,
    input  logic [4:0]                   exu_waddr_i,
    input  logic [XLEN-1:0]              exu_wdata_i,
    input  logic [XLEN-1:0]              exu_csr_wdata_i,
    input  logic [XLEN-1:0]              exu_pc_i,
    input  logic [CSR_DIFF_N*XLEN-1:0]   exu_csr_diff_i,
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic                         lsu_we_i,
    input  logic [4:0]                   lsu_waddr_i,
    input  logic [XLEN-1:0]              lsu_wdata_i,
    input  logic [XLEN-1:0]              lsu_pc_i,
    input  logic [CSR_DIFF_N*XLEN-1:0]   lsu_csr_diff_i,
    output logic                         wb_we_o,
    output logic [4:0]                   wb_waddr_o,
    output logic [XLEN-1:0]              wb_wdata_o,
    output logic                         commit_valid_o,
    output logic [XLEN-1:0]              commit_pc_o,
    output logic [CSR_DIFF_N*XLEN-1:0]   commit_csr_diff_o,
    output logic [63:0]                  instret_o
);

    logic    exu_grant;
    logic    lsu_grant;
    wb_src_e src;
    wb_req_t sel;

    ysyx_22050019_wb_age_prio #(
        .AGE_MAX (AGE_MAX)
    ) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .exu_valid (exu_valid_i),
        .lsu_valid (lsu_valid_i),
        .exu_grant (exu_grant),
        .lsu_grant (lsu_grant),
        .src       (src)
    );

    assign exu_ready_o = exu_grant;
    assign lsu_ready_o = lsu_grant;

    // Select the granted payload; all-zero when nobody is granted.
    always_comb begin
        sel = '0;
        case (src)
            WB_EXU: begin
                sel.we       = exu_we_i;
                sel.waddr    = exu_waddr_i;
                sel.wdata    = exu_wdata_i | exu_csr_wdata_i;
                sel.pc       = exu_pc_i;
                sel.csr_diff = exu_csr_diff_i;
            end
            WB_LSU: begin
                sel.we       = lsu_we_i;
                sel.waddr    = lsu_waddr_i;
                sel.wdata    = lsu_wdata_i;
                sel.pc       = lsu_pc_i;
                sel.csr_diff = lsu_csr_diff_i;
            end
            default: ;
        endcase
    end

    // Output stage: one-cycle registered write port, commit record and instret.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_o           <= 1'b0;
            wb_waddr_o        <= 5'd0;
            wb_wdata_o        <= '0;
            commit_valid_o    <= 1'b0;
            commit_pc_o       <= '0;
            commit_csr_diff_o <= '0;
            instret_o         <= 64'd0;
        end else begin
            // x0 writes are dropped but the instruction still retires.
            wb_we_o           <= sel.we && (sel.waddr != 5'd0);
            wb_waddr_o        <= sel.waddr;
            wb_wdata_o        <= sel.wdata;
            commit_valid_o    <= (src != WB_NONE);
            commit_pc_o       <= sel.pc;
            commit_csr_diff_o <= sel.csr_diff;
            if (src != WB_NONE) begin
                instret_o <= instret_o + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_wb_arbiter.sv
// Directed and randomized bench for the write-back arbiter, checked against
// a transaction-level reference model (grant rule + lost-cycle count).
module tb_ysyx_22050019_wb_arbiter;

    localparam int AGE_MAX = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         exu_valid_i = 1'b0;
    logic         exu_ready_o;
    logic         exu_we_i = 1'b0;
    logic [4:0]   exu_waddr_i = '0;
    logic [63:0]  exu_wdata_i = '0;
    logic [63:0]  exu_csr_wdata_i = '0;
    logic [63:0]  exu_pc_i = '0;
    logic [255:0] exu_csr_diff_i = '0;
    logic         lsu_valid_i = 1'b0;
    logic         lsu_ready_o;
    logic         lsu_we_i = 1'b0;
    logic [4:0]   lsu_waddr_i = '0;
    logic [63:0]  lsu_wdata_i = '0;
    logic [63:0]  lsu_pc_i = '0;
    logic [255:0] lsu_csr_diff_i = '0;
    logic         wb_we_o;
    logic [4:0]   wb_waddr_o;
    logic [63:0]  wb_wdata_o;
    logic         commit_valid_o;
    logic [63:0]  commit_pc_o;
    logic [255:0] commit_csr_diff_o;
    logic [63:0]  instret_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: consecutive lost EXU cycles and retired count.
    int          m_age = 0;
    logic [63:0] m_instret = '0;
    bit          last_e = 0;
    bit          last_l = 0;
    logic [63:0] instret_mark;

    ysyx_22050019_wb_arbiter #(.AGE_MAX(AGE_MAX)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exu_valid_i       (exu_valid_i),
        .exu_ready_o       (exu_ready_o),
        .exu_we_i          (exu_we_i),
        .exu_waddr_i       (exu_waddr_i),
        .exu_wdata_i       (exu_wdata_i),
        .exu_csr_wdata_i   (exu_csr_wdata_i),
        .exu_pc_i          (exu_pc_i),
        .exu_csr_diff_i    (exu_csr_diff_i),
        .lsu_valid_i       (lsu_valid_i),
        .lsu_ready_o       (lsu_ready_o),
        .lsu_we_i          (lsu_we_i),
        .lsu_waddr_i       (lsu_waddr_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .lsu_pc_i          (lsu_pc_i),
        .lsu_csr_diff_i    (lsu_csr_diff_i),
        .wb_we_o           (wb_we_o),
        .wb_waddr_o        (wb_waddr_o),
        .wb_wdata_o        (wb_wdata_o),
        .commit_valid_o    (commit_valid_o),
        .commit_pc_o       (commit_pc_o),
        .commit_csr_diff_o (commit_csr_diff_o),
        .instret_o         (instret_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock cycle: predict grant and the registered outputs from the
    // current inputs, then compare after the edge.
    task automatic cycle();
        bit g_e, g_l;
        logic e_we;
        logic [4:0] e_addr;
        logic [63:0] e_data, e_pc;
        logic [255:0] e_csr;
        #1;
        if (exu_valid_i && lsu_valid_i) begin
            g_l = (m_age != AGE_MAX);
            g_e = !g_l;
        end else begin
            g_l = lsu_valid_i;
            g_e = exu_valid_i;
        end
        chk("exu_ready", 256'(exu_ready_o), 256'(g_e));
        chk("lsu_ready", 256'(lsu_ready_o), 256'(g_l));
        e_we = 0; e_addr = 0; e_data = 0; e_pc = 0; e_csr = 0;
        if (g_e) begin
            e_we = exu_we_i && exu_waddr_i != 0;
            e_addr = exu_waddr_i;
            e_data = exu_wdata_i | exu_csr_wdata_i;
            e_pc = exu_pc_i;
            e_csr = exu_csr_diff_i;
        end else if (g_l) begin
            e_we = lsu_we_i && lsu_waddr_i != 0;
            e_addr = lsu_waddr_i;
            e_data = lsu_wdata_i;
            e_pc = lsu_pc_i;
            e_csr = lsu_csr_diff_i;
        end
        if (exu_valid_i && !g_e) m_age = (m_age < AGE_MAX) ? m_age + 1 : AGE_MAX;
        else m_age = 0;
        if (g_e || g_l) m_instret = m_instret + 64'd1;
        @(posedge clk);
        #1;
        chk("wb_we", 256'(wb_we_o), 256'(e_we));
        chk("wb_waddr", 256'(wb_waddr_o), 256'(e_addr));
        chk("wb_wdata", 256'(wb_wdata_o), 256'(e_data));
        chk("commit_valid", 256'(commit_valid_o), 256'(g_e || g_l));
        chk("commit_pc", 256'(commit_pc_o), 256'(e_pc));
        chk("commit_csr", commit_csr_diff_o, e_csr);
        chk("instret", 256'(instret_o), 256'(m_instret));
        chk("age", 256'(u_dut.u_prio.age_q), 256'(m_age));
        last_e = g_e;
        last_l = g_l;
    endtask

    task automatic new_exu(input bit v);
        exu_valid_i = v;
        exu_we_i = $urandom_range(0, 3) != 0;
        exu_waddr_i = 5'($urandom_range(0, 31));
        exu_wdata_i = {$urandom, $urandom};
        exu_csr_wdata_i = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'd0;
        exu_pc_i = {32'd0, $urandom};
        exu_csr_diff_i = rand256();
    endtask

    task automatic new_lsu(input bit v);
        lsu_valid_i = v;
        lsu_we_i = $urandom_range(0, 3) != 0;
        lsu_waddr_i = 5'($urandom_range(0, 31));
        lsu_wdata_i = {$urandom, $urandom};
        lsu_pc_i = {32'd0, $urandom};
        lsu_csr_diff_i = rand256();
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit_valid", 256'(commit_valid_o), 256'(0));
        chk("rst_instret", 256'(instret_o), 256'(0));
        chk("rst_wb_wdata", 256'(wb_wdata_o), 256'(0));
        rst_n = 1'b1;

        // EXU only.
        exu_valid_i = 1; exu_we_i = 1; exu_waddr_i = 5; exu_wdata_i = 64'h10;
        exu_csr_wdata_i = 64'h3; exu_pc_i = 64'h8000_0000; exu_csr_diff_i = rand256();
        cycle();
        chk("exu_only_wdata", 256'(wb_wdata_o), 256'(64'h13));
        chk("exu_only_instret", 256'(instret_o), 256'(1));
        exu_valid_i = 0;
        cycle();

        // Collision: LSU first, EXU next.
        instret_mark = m_instret;
        new_exu(1); exu_we_i = 1; exu_waddr_i = 3;
        new_lsu(1); lsu_we_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 64'hAA;
        cycle();
        chk("coll_first_lsu", 256'(last_l), 256'(1));
        chk("coll_waddr7", 256'(wb_waddr_o), 256'(7));
        chk("coll_wdataAA", 256'(wb_wdata_o), 256'(64'hAA));
        lsu_valid_i = 0;
        cycle();
        chk("coll_then_exu", 256'(last_e), 256'(1));
        chk("coll_waddr3", 256'(wb_waddr_o), 256'(3));
        chk("coll_instret2", 256'(instret_o - instret_mark), 256'(2));
        exu_valid_i = 0;
        cycle();

        // Starvation: LSU wins AGE_MAX cycles, EXU wins the next one.
        new_exu(1);
        new_lsu(1);
        for (int k = 0; k <= AGE_MAX; k++) begin
            cycle();
            chk("starve_exu_grant", 256'(last_e), 256'(k == AGE_MAX));
            if (last_l) new_lsu(1);
        end
        chk("starve_age_cleared", 256'(u_dut.u_prio.age_q), 256'(0));
        exu_valid_i = 0; lsu_valid_i = 0;
        cycle();

        // x0 write: retires but does not write.
        instret_mark = m_instret;
        new_lsu(1); lsu_we_i = 1; lsu_waddr_i = 0; lsu_wdata_i = 64'hFFFF;
        cycle();
        chk("x0_we", 256'(wb_we_o), 256'(0));
        chk("x0_commit", 256'(commit_valid_o), 256'(1));
        chk("x0_instret", 256'(instret_o - instret_mark), 256'(1));
        lsu_valid_i = 0;

        // Reset asynchronously while a grant sits in the output register.
        new_exu(1); exu_we_i = 1; exu_waddr_i = 9;
        cycle();
        exu_valid_i = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_commit", 256'(commit_valid_o), 256'(0));
        chk("arst_we", 256'(wb_we_o), 256'(0));
        chk("arst_pc", 256'(commit_pc_o), 256'(0));
        chk("arst_csr", commit_csr_diff_o, 256'(0));
        chk("arst_instret", 256'(instret_o), 256'(0));
        m_age = 0;
        m_instret = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_commit", 256'(commit_valid_o), 256'(0));

        // Idle for 10 cycles.
        instret_mark = m_instret;
        for (int k = 0; k < 10; k++) cycle();
        chk("idle_instret", 256'(instret_o), 256'(instret_mark));

        // Randomized traffic; each source holds its offer until accepted.
        new_exu(0);
        new_lsu(0);
        for (int k = 0; k < 400; k++) begin
            cycle();
            if (!exu_valid_i || last_e) new_exu($urandom_range(0, 99) < 60);
            if (!lsu_valid_i || last_l) new_lsu($urandom_range(0, 99) < 55);
        end
        exu_valid_i = 0;
        lsu_valid_i = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
